cap_sync_ctrl: RTL
==================

CAP_SYNC_CTRL -- requirements
Module: cap_sync_ctrl

Interface
REQ-001 Parameter WIDTH, default 16: period counter and period output width.
REQ-002 Parameter TOOTH_W, default 6: tooth index width.
REQ-003 Parameter TEETH, default 58: real teeth per revolution (60-2 wheel); SHALL satisfy TEETH < 2**TOOTH_W.
REQ-004 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-005 Port arst, input, 1: reset, asynchronous and active-high.
REQ-006 Port ena, input, 1: controller enable, synchronous, level.
REQ-007 Port edge, input, 1: one-cycle pulse per tooth edge, already synchronized to clk.
REQ-008 Port period, output, WIDTH: last captured edge-to-edge period, in clk cycles.
REQ-009 Port period_valid, output, 1: one-cycle pulse when period updates.
REQ-010 Port gap, output, 1: one-cycle pulse when the captured period is a missing-tooth gap.
REQ-011 Port tooth_num, output, TOOTH_W: tooth index since last gap; gap-ending edge = 0.
REQ-012 Port synced, output, 1: level, wheel position valid.
REQ-013 Port sync_err, output, 1: one-cycle pulse on tooth-count mismatch.
REQ-014 Port ovf, output, 1: one-cycle pulse on period counter saturation.

Function
REQ-015 States: IDLE, FIRST (wait start edge), MEASURE (one edge seen, no previous period), RUN.
REQ-016 ena=0 SHALL force IDLE next cycle from any state, clear cnt, synced and tooth_num, and suppress all pulses; period holds.
REQ-017 IDLE with ena=1 -> FIRST next cycle.
REQ-018 FIRST: edge -> MEASURE, cnt loads 1; otherwise cnt holds 0.
REQ-019 In MEASURE/RUN, cnt increments by 1 per cycle without an edge.
REQ-020 On an edge in MEASURE/RUN: period <= cnt, cnt <= 1, and period_valid pulses in the following cycle; edges N cycles apart SHALL yield period = N.
REQ-021 MEASURE edge -> RUN; no gap evaluation; prev_period <= cnt.
REQ-022 RUN edge: gap = (cnt >= 2*prev_period), compared in WIDTH+1 bits with no truncation; prev_period <= cnt.
REQ-023 Gap while synced=0: synced <= 1, tooth_num <= 0, gap pulses.
REQ-024 Gap while synced=1: if tooth_num == TEETH-1, tooth_num <= 0 and gap pulses; otherwise sync_err pulses, gap pulses, synced <= 0, tooth_num <= 0.
REQ-025 Non-gap RUN edge while synced=1: tooth_num <= tooth_num+1; if tooth_num == TEETH-1 beforehand, sync_err pulses, synced <= 0, tooth_num <= 0.
REQ-026 Non-gap RUN edge while synced=0: tooth_num holds 0.
REQ-027 cnt reaching all-ones in MEASURE/RUN without an edge: ovf pulses, synced <= 0, tooth_num <= 0, cnt <= 0, state -> FIRST.
REQ-028 Edge in the same cycle as saturation: edge wins; period = all-ones is captured per REQ-020, and ovf does not pulse.
REQ-029 Edges in IDLE are ignored; in FIRST they only start measurement.
REQ-030 All outputs SHALL be registered; pulses last exactly one cycle.

Reset
REQ-031 arst SHALL asynchronously set state=IDLE, cnt=0, prev_period=0, period=0, tooth_num=0, and all 1-bit outputs=0.
REQ-032 On arst deassertion, the controller waits in IDLE until ena=1; an arst mid-measurement discards the partial period.

Structure
REQ-033 Package cap_sync_pkg SHALL hold the state enum and the default WIDTH/TOOTH_W/TEETH constants.
REQ-034 The period count SHALL use one instance of the team's up/down counter (sel=0, sload for the 1/0 loads, srst unused, arst shared); FSM, comparator and tooth logic stay in cap_sync_ctrl.

Verification
REQ-035 Bench: arst, ena=1, edges every 100 cycles -> first period_valid with period=100 on the second edge; synced=0.
REQ-036 Bench: 58 edges at 100 cycles, then a 300-cycle gap, repeated twice -> gap pulses, synced=1, tooth_num 0..57, no sync_err.
REQ-037 Bench: synced, then a gap after only 40 teeth -> sync_err and gap in the same cycle, synced=0, tooth_num=0.
REQ-038 Bench: WIDTH=8, no edge for 300 cycles after start -> ovf pulse at cnt=255, state FIRST, synced=0.
REQ-039 Bench: edge coincident with cnt=all-ones -> period=255, period_valid=1, ovf=0.
REQ-040 Bench: arst pulse, and separately ena=0, mid-revolution -> all outputs per REQ-031/REQ-016; resync requires a fresh gap.

Source files
------------

// File: rtl/cap_sync_pkg.sv
// Shared types and default sizing for the crank-wheel capture/sync controller.
package cap_sync_pkg;

  localparam int unsigned DEF_WIDTH   = 16;
  localparam int unsigned DEF_TOOTH_W = 6;
  localparam int unsigned DEF_TEETH   = 58;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StFirst   = 2'd1,
    StMeasure = 2'd2,
    StRun     = 2'd3
  } state_e;

endpackage

// File: rtl/cap_sync_ctrl_updn.sv
// Generic up/down counter with synchronous reset, synchronous load and count enable.
module cap_sync_ctrl_updn #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             srst,
  input  logic             ena,
  input  logic             sel,
  input  logic             sload,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt
);

  // Priority: srst over sload over counting; sel=1 counts down.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt <= '0;
    end else if (srst) begin
      cnt <= '0;
    end else if (sload) begin
      cnt <= load_val;
    end else if (ena) begin
      cnt <= sel ? cnt - WIDTH'(1) : cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cap_sync_ctrl.sv
// Tooth-period capture and missing-tooth synchronisation for a toothed crank wheel.
// The tooth strobe is named tooth_edge because "edge" is a reserved word.
module cap_sync_ctrl
  import cap_sync_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned TOOTH_W = DEF_TOOTH_W,
  parameter int unsigned TEETH   = DEF_TEETH
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               ena,
  input  logic               tooth_edge,
  output logic [WIDTH-1:0]   period,
  output logic               period_valid,
  output logic               gap,
  output logic [TOOTH_W-1:0] tooth_num,
  output logic               synced,
  output logic               sync_err,
  output logic               ovf
);

  localparam logic [WIDTH-1:0]   CntMax    = '1;
  localparam logic [TOOTH_W-1:0] LastTooth = TOOTH_W'(TEETH - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     cnt, cnt_load;
  logic                 cnt_sload, cnt_inc;
  logic [WIDTH-1:0]     period_q, period_d, prev_q, prev_d;
  logic [TOOTH_W-1:0]   tooth_q, tooth_d;
  logic                 synced_q, synced_d;
  logic                 pv_q, pv_d, gap_q, gap_d, err_q, err_d, ovf_q, ovf_d;
  logic                 is_gap;

  cap_sync_ctrl_updn #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk      (clk),
    .arst     (arst),
    .srst     (1'b0),
    .ena      (cnt_inc),
    .sel      (1'b0),
    .sload    (cnt_sload),
    .load_val (cnt_load),
    .cnt      (cnt)
  );

  // Extra bit keeps 2*prev from wrapping.
  assign is_gap = {1'b0, cnt} >= {prev_q, 1'b0};

  always_comb begin
    state_d   = state_q;
    cnt_sload = 1'b0;
    cnt_load  = '0;
    cnt_inc   = 1'b0;
    period_d  = period_q;
    prev_d    = prev_q;
    tooth_d   = tooth_q;
    synced_d  = synced_q;
    pv_d      = 1'b0;
    gap_d     = 1'b0;
    err_d     = 1'b0;
    ovf_d     = 1'b0;

    if (!ena) begin
      state_d   = StIdle;
      cnt_sload = 1'b1;
      synced_d  = 1'b0;
      tooth_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d   = StFirst;
          cnt_sload = 1'b1;
        end
        StFirst: begin
          cnt_sload = 1'b1;
          if (tooth_edge) begin
            cnt_load = WIDTH'(1);
            state_d  = StMeasure;
          end
        end
        StMeasure, StRun: begin
          if (tooth_edge) begin
            cnt_sload = 1'b1;
            cnt_load  = WIDTH'(1);
            period_d  = cnt;
            prev_d    = cnt;
            pv_d      = 1'b1;
            state_d   = StRun;
            if (state_q == StRun) begin
              if (is_gap) begin
                gap_d   = 1'b1;
                tooth_d = '0;
                if (synced_q && tooth_q != LastTooth) begin
                  err_d    = 1'b1;
                  synced_d = 1'b0;
                end else begin
                  synced_d = 1'b1;
                end
              end else if (synced_q) begin
                if (tooth_q == LastTooth) begin
                  err_d    = 1'b1;
                  synced_d = 1'b0;
                  tooth_d  = '0;
                end else begin
                  tooth_d = tooth_q + TOOTH_W'(1);
                end
              end else begin
                tooth_d = '0;
              end
            end
          end else if (cnt == CntMax) begin
            // Wheel stalled: drop sync and wait for a fresh start edge.
            cnt_sload = 1'b1;
            ovf_d     = 1'b1;
            synced_d  = 1'b0;
            tooth_d   = '0;
            state_d   = StFirst;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q  <= StIdle;
      period_q <= '0;
      prev_q   <= '0;
      tooth_q  <= '0;
      synced_q <= 1'b0;
      pv_q     <= 1'b0;
      gap_q    <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      prev_q   <= prev_d;
      tooth_q  <= tooth_d;
      synced_q <= synced_d;
      pv_q     <= pv_d;
      gap_q    <= gap_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  assign period       = period_q;
  assign period_valid = pv_q;
  assign gap          = gap_q;
  assign tooth_num    = tooth_q;
  assign synced       = synced_q;
  assign sync_err     = err_q;
  assign ovf          = ovf_q;

endmodule
